// File: rtl/tlb_pkg.sv
// Shared definitions for the 16-entry software-managed TLB.
// Holds the packed entry layout, field widths, INVTLB op codes, the two
// legal page sizes and a small helper that classifies an entry's page size.
package tlb_pkg;

    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    localparam int VPPN_W = 19;
    localparam int PS_W   = 6;
    localparam int ASID_W = 10;
    localparam int PPN_W  = 20;
    localparam int ENTRY_W = 89;

    localparam logic [PS_W-1:0] PS_4K = 6'd12;
    localparam logic [PS_W-1:0] PS_4M = 6'd21;

    localparam logic [4:0] INV_ALL0        = 5'd0;
    localparam logic [4:0] INV_ALL1        = 5'd1;
    localparam logic [4:0] INV_G1          = 5'd2;
    localparam logic [4:0] INV_G0          = 5'd3;
    localparam logic [4:0] INV_G0_ASID     = 5'd4;
    localparam logic [4:0] INV_G0_ASID_VA  = 5'd5;
    localparam logic [4:0] INV_GASID_VA    = 5'd6;
    localparam logic [4:0] INV_OP_MAX      = 5'd6;

    // Field order MSB to LSB matches the CSR-side packing of TLBWR/TLBRD.
    typedef struct packed {
        logic              e;
        logic [VPPN_W-1:0] vppn;
        logic [PS_W-1:0]   ps;
        logic              g;
        logic [ASID_W-1:0] asid;
        logic [PPN_W-1:0]  ppn0;
        logic [1:0]        plv0;
        logic [1:0]        mat0;
        logic              d0;
        logic              v0;
        logic [PPN_W-1:0]  ppn1;
        logic [1:0]        plv1;
        logic [1:0]        mat1;
        logic              d1;
        logic              v1;
    } tlb_entry_t;

    // Anything that is not exactly 21 behaves as a 4K page.
    function automatic logic is_4m(input logic [PS_W-1:0] ps);
        return ps == PS_4M;
    endfunction

endpackage

// File: rtl/tlb_array_if.sv
// Bus bundle between the translator/CSR side (master) and tlb_array (slave).
// Groups: search request/response, TLBWR/TLBFILL write, TLBRD read,
// INVTLB request plus its bad-op flag, and the TLBFILL victim index.
interface tlb_array_if;

    logic [tlb_pkg::VPPN_W-1:0] s_vppn;
    logic                       s_va_bit12;
    logic [tlb_pkg::ASID_W-1:0] s_asid;
    logic                       s_found;
    logic [tlb_pkg::IDXW-1:0]   s_index;
    logic [tlb_pkg::PPN_W-1:0]  s_ppn;
    logic [tlb_pkg::PS_W-1:0]   s_ps;
    logic [1:0]                 s_plv;
    logic [1:0]                 s_mat;
    logic                       s_d;
    logic                       s_v;

    logic                       we;
    logic [tlb_pkg::IDXW-1:0]   w_index;
    tlb_pkg::tlb_entry_t        w_entry;

    logic [tlb_pkg::IDXW-1:0]   r_index;
    tlb_pkg::tlb_entry_t        r_entry;

    logic                       inv_valid;
    logic [4:0]                 inv_op;
    logic [tlb_pkg::ASID_W-1:0] inv_asid;
    logic [tlb_pkg::VPPN_W-1:0] inv_vppn;
    logic                       inv_op_bad;

    logic [tlb_pkg::IDXW-1:0]   fill_index;

    modport master (
        output s_vppn, s_va_bit12, s_asid,
        output we, w_index, w_entry, r_index,
        output inv_valid, inv_op, inv_asid, inv_vppn,
        input  s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
        input  r_entry, inv_op_bad, fill_index
    );

    modport slave (
        input  s_vppn, s_va_bit12, s_asid,
        input  we, w_index, w_entry, r_index,
        input  inv_valid, inv_op, inv_asid, inv_vppn,
        output s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
        output r_entry, inv_op_bad, fill_index
    );

endinterface

// File: rtl/tlb_match.sv
// Per-entry combinational compare of one stored entry against a request.
// Ports:
//   vppn_i/ps_i/g_i/asid_i        stored entry tag fields
//   req_vppn_i/req_bit12_i/req_asid_i  request VA[31:13], VA[12], ASID
//   match_o     (g or ASID equal) and VPPN equal at the entry's page size
//   asid_hit_o  g or ASID equal (lets the caller build the g=0 INVTLB ops)
//   sel_o       odd/even half select for this entry's page size
// The e bit is deliberately not looked at here; the caller qualifies it.
module tlb_match
    import tlb_pkg::*;
(
    input  logic [VPPN_W-1:0] vppn_i,
    input  logic [PS_W-1:0]   ps_i,
    input  logic              g_i,
    input  logic [ASID_W-1:0] asid_i,
    input  logic [VPPN_W-1:0] req_vppn_i,
    input  logic              req_bit12_i,
    input  logic [ASID_W-1:0] req_asid_i,
    output logic              match_o,
    output logic              asid_hit_o,
    output logic              sel_o
);

    logic big;
    logic vppn_hit;

    assign big        = is_4m(ps_i);
    // A 4M page covers 512 VPPNs, so only VA[31:22] takes part in the tag.
    assign vppn_hit   = big ? (vppn_i[VPPN_W-1:9] == req_vppn_i[VPPN_W-1:9])
                            : (vppn_i == req_vppn_i);
    assign asid_hit_o = g_i || (asid_i == req_asid_i);
    assign match_o    = asid_hit_o && vppn_hit;
    // VA[21] picks the half of a 4M page, VA[12] the half of a 4K page.
    assign sel_o      = big ? req_vppn_i[8] : req_bit12_i;

endmodule

// File: rtl/tlb_array.sv
// 16-entry fully associative TLB storage and search.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset; clears every field of every entry
//   tlb     tlb_array_if.slave: combinational search, TLBWR/TLBFILL write,
//           TLBRD read, INVTLB invalidate (+ inv_op_bad), fill_index victim
// Search and read are zero-latency from the registered storage; writes and
// invalidates take effect at the clock edge.
module tlb_array
    import tlb_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    tlb_array_if.slave  tlb
);

    tlb_entry_t        entry_q [TLBNUM];
    tlb_entry_t        entry_d [TLBNUM];
    logic [IDXW-1:0]   fill_q;
    logic [IDXW-1:0]   fill_d;

    logic [TLBNUM-1:0] s_match;
    logic [TLBNUM-1:0] s_sel;
    logic [TLBNUM-1:0] s_asid_hit_unused;
    logic [TLBNUM-1:0] s_hit;
    logic [TLBNUM-1:0] inv_match;
    logic [TLBNUM-1:0] inv_asid_hit;
    logic [TLBNUM-1:0] inv_sel_unused;
    logic [TLBNUM-1:0] inv_hit;

    logic              hit_found;
    logic [IDXW-1:0]   hit_idx;
    tlb_entry_t        hit_e;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_cmp
        tlb_match u_search (
            .vppn_i      (entry_q[i].vppn),
            .ps_i        (entry_q[i].ps),
            .g_i         (entry_q[i].g),
            .asid_i      (entry_q[i].asid),
            .req_vppn_i  (tlb.s_vppn),
            .req_bit12_i (tlb.s_va_bit12),
            .req_asid_i  (tlb.s_asid),
            .match_o     (s_match[i]),
            .asid_hit_o  (s_asid_hit_unused[i]),
            .sel_o       (s_sel[i])
        );

        tlb_match u_inv (
            .vppn_i      (entry_q[i].vppn),
            .ps_i        (entry_q[i].ps),
            .g_i         (entry_q[i].g),
            .asid_i      (entry_q[i].asid),
            .req_vppn_i  (tlb.inv_vppn),
            .req_bit12_i (1'b0),
            .req_asid_i  (tlb.inv_asid),
            .match_o     (inv_match[i]),
            .asid_hit_o  (inv_asid_hit[i]),
            .sel_o       (inv_sel_unused[i])
        );

        assign s_hit[i] = entry_q[i].e && s_match[i];

        // With g=0, asid_hit reduces to a pure ASID compare.
        always_comb begin
            inv_hit[i] = 1'b0;
            case (tlb.inv_op)
                INV_ALL0, INV_ALL1: inv_hit[i] = 1'b1;
                INV_G1:             inv_hit[i] = entry_q[i].g;
                INV_G0:             inv_hit[i] = !entry_q[i].g;
                INV_G0_ASID:        inv_hit[i] = !entry_q[i].g && inv_asid_hit[i];
                INV_G0_ASID_VA:     inv_hit[i] = !entry_q[i].g && inv_match[i];
                INV_GASID_VA:       inv_hit[i] = inv_match[i];
                default:            inv_hit[i] = 1'b0;
            endcase
        end
    end

    // Lowest index wins: scan downward so the last assignment is the smallest hit.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (s_hit[i]) begin
                hit_found = 1'b1;
                hit_idx   = IDXW'(i);
            end
        end
    end

    always_comb begin
        hit_e          = entry_q[hit_idx];
        tlb.s_found    = hit_found;
        tlb.s_index    = '0;
        tlb.s_ppn      = '0;
        tlb.s_ps       = '0;
        tlb.s_plv      = '0;
        tlb.s_mat      = '0;
        tlb.s_d        = 1'b0;
        tlb.s_v        = 1'b0;
        if (hit_found) begin
            tlb.s_index = hit_idx;
            tlb.s_ps    = is_4m(hit_e.ps) ? PS_4M : PS_4K;
            if (s_sel[hit_idx]) begin
                tlb.s_ppn = hit_e.ppn1;
                tlb.s_plv = hit_e.plv1;
                tlb.s_mat = hit_e.mat1;
                tlb.s_d   = hit_e.d1;
                tlb.s_v   = hit_e.v1;
            end else begin
                tlb.s_ppn = hit_e.ppn0;
                tlb.s_plv = hit_e.plv0;
                tlb.s_mat = hit_e.mat0;
                tlb.s_d   = hit_e.d0;
                tlb.s_v   = hit_e.v0;
            end
        end
    end

    assign tlb.r_entry    = entry_q[tlb.r_index];
    assign tlb.inv_op_bad = tlb.inv_valid && (tlb.inv_op > INV_OP_MAX);
    assign tlb.fill_index = fill_q;

    // Invalidate first, then the write, so a same-cycle write always lands intact.
    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            entry_d[i] = entry_q[i];
            if (tlb.inv_valid && inv_hit[i]) begin
                entry_d[i].e = 1'b0;
            end
        end
        if (tlb.we) begin
            entry_d[tlb.w_index] = tlb.w_entry;
        end
    end

    // TLBNUM is a power of two, so the natural wrap of the counter is the victim wrap.
    assign fill_d = fill_q + IDXW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                entry_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int i = 0; i < TLBNUM; i++) begin
                entry_q[i] <= entry_d[i];
            end
            fill_q <= fill_d;
        end
    end

endmodule

// File: tb/tb_tlb_array.sv
module tb_tlb_array;
    import tlb_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    tlb_array_if bus ();

    tlb_array dut (
        .clk    (clk),
        .resetn (resetn),
        .tlb    (bus)
    );

    typedef struct {
        logic        found;
        logic [3:0]  idx;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
        tlb_entry_t  rent;
        logic        bad;
        logic [3:0]  fill;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_x;
    int         checks = 0;
    int         failures = 0;
    bit         done = 1'b0;

    // Reference state: plain array of entries plus a victim counter.
    tlb_entry_t m [16];
    int         m_fill;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m[i] = '0;
        m_fill = 0;
    endfunction

    function automatic bit page_hit(input tlb_entry_t e, input logic [18:0] va_vppn);
        if (e.ps == 6'd21) return (int'(e.vppn) >> 9) == (int'(va_vppn) >> 9);
        return e.vppn == va_vppn;
    endfunction

    function automatic void model_search(input logic [18:0] vppn, input logic b12,
                                         input logic [9:0] asid, output exp_t x);
        x = '{default: '0};
        for (int i = 0; i < 16; i++) begin
            tlb_entry_t e;
            int half;
            e = m[i];
            if (e.e && (e.g || e.asid == asid) && page_hit(e, vppn)) begin
                half       = (e.ps == 6'd21) ? ((int'(vppn) >> 8) & 1) : int'(b12);
                x.found    = 1'b1;
                x.idx      = 4'(i);
                x.ps       = (e.ps == 6'd21) ? 6'd21 : 6'd12;
                x.ppn      = half ? e.ppn1 : e.ppn0;
                x.plv      = half ? e.plv1 : e.plv0;
                x.mat      = half ? e.mat1 : e.mat0;
                x.d        = half ? e.d1   : e.d0;
                x.v        = half ? e.v1   : e.v0;
                break;
            end
        end
    endfunction

    function automatic void model_apply();
        if (!resetn) begin
            model_reset();
            return;
        end
        if (bus.inv_valid) begin
            for (int i = 0; i < 16; i++) begin
                bit kill;
                bit same_asid;
                same_asid = (m[i].asid == bus.inv_asid);
                case (int'(bus.inv_op))
                    0, 1:    kill = 1;
                    2:       kill = m[i].g;
                    3:       kill = !m[i].g;
                    4:       kill = !m[i].g && same_asid;
                    5:       kill = !m[i].g && same_asid && page_hit(m[i], bus.inv_vppn);
                    6:       kill = (m[i].g || same_asid) && page_hit(m[i], bus.inv_vppn);
                    default: kill = 0;
                endcase
                if (kill) m[i].e = 1'b0;
            end
        end
        if (bus.we) m[bus.w_index] = bus.w_entry;
        m_fill = (m_fill + 1) % 16;
    endfunction

    task automatic cycle();
        exp_t x;
        model_search(bus.s_vppn, bus.s_va_bit12, bus.s_asid, x);
        x.rent = m[bus.r_index];
        x.bad  = bus.inv_valid && (int'(bus.inv_op) > 6);
        x.fill = 4'(m_fill);
        sb_q.push_back(x);
        @(posedge clk);
        model_apply();
        #1;
    endtask

    task automatic write(input int idx, input tlb_entry_t ent);
        bus.we      = 1'b1;
        bus.w_index = 4'(idx);
        bus.w_entry = ent;
        cycle();
        bus.we      = 1'b0;
    endtask

    task automatic invalidate(input int op, input logic [9:0] asid, input logic [18:0] vppn);
        bus.inv_valid = 1'b1;
        bus.inv_op    = 5'(op);
        bus.inv_asid  = asid;
        bus.inv_vppn  = vppn;
        cycle();
        bus.inv_valid = 1'b0;
    endtask

    task automatic search(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
        bus.s_vppn     = vppn;
        bus.s_va_bit12 = b12;
        bus.s_asid     = asid;
        cycle();
    endtask

    function automatic logic [18:0] pick_vppn();
        case ($urandom_range(0, 3))
            0:       return 19'h12345;
            1:       return 19'h7FE00 | 19'($urandom_range(0, 511));
            2:       return 19'h00001;
            default: return 19'($urandom);
        endcase
    endfunction

    function automatic logic [9:0] pick_asid();
        return $urandom_range(0, 1) ? 10'h2A : 10'h2B;
    endfunction

    function automatic tlb_entry_t rand_entry();
        tlb_entry_t e;
        e      = tlb_entry_t'({$urandom, $urandom, $urandom});
        e.e    = ($urandom_range(0, 3) != 0);
        e.vppn = pick_vppn();
        case ($urandom_range(0, 3))
            0:       e.ps = 6'd12;
            1, 2:    e.ps = 6'd21;
            default: e.ps = 6'($urandom);
        endcase
        e.asid = pick_asid();
        return e;
    endfunction

    // Monitor: one expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [36:0] act_s;
            logic [36:0] exp_s;
            mon_x = sb_q.pop_front();
            act_s = {bus.s_found, bus.s_index, bus.s_ppn, bus.s_ps, bus.s_plv, bus.s_mat, bus.s_d, bus.s_v};
            exp_s = {mon_x.found, mon_x.idx, mon_x.ppn, mon_x.ps, mon_x.plv, mon_x.mat, mon_x.d, mon_x.v};
            checks++;
            if (act_s !== exp_s) begin
                failures++;
                $display("FAIL search t=%0t got=%h want=%h", $time, act_s, exp_s);
            end
            checks++;
            if (bus.r_entry !== mon_x.rent) begin
                failures++;
                $display("FAIL r_entry t=%0t got=%h want=%h", $time, bus.r_entry, mon_x.rent);
            end
            checks++;
            if (bus.inv_op_bad !== mon_x.bad) begin
                failures++;
                $display("FAIL inv_op_bad t=%0t got=%b want=%b", $time, bus.inv_op_bad, mon_x.bad);
            end
            checks++;
            if (bus.fill_index !== mon_x.fill) begin
                failures++;
                $display("FAIL fill_index t=%0t got=%0d want=%0d", $time, bus.fill_index, mon_x.fill);
            end
        end else if (done) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        tlb_entry_t a, a2, b, c, cz, d;

        resetn         = 1'b0;
        bus.s_vppn     = 19'h00001;
        bus.s_va_bit12 = 1'b0;
        bus.s_asid     = 10'h0;
        bus.we         = 1'b0;
        bus.w_index    = '0;
        bus.w_entry    = '0;
        bus.r_index    = 4'd5;
        bus.inv_valid  = 1'b0;
        bus.inv_op     = '0;
        bus.inv_asid   = '0;
        bus.inv_vppn   = '0;
        model_reset();

        @(posedge clk);
        #1;
        cycle();
        cycle();
        resetn = 1'b1;
        // Counter runs through a full wrap with nothing matching.
        repeat (18) cycle();

        a = '0;
        a.e = 1'b1; a.vppn = 19'h12345; a.ps = 6'd12; a.g = 1'b0; a.asid = 10'h2A;
        a.ppn0 = 20'hAAAAA; a.v0 = 1'b1; a.ppn1 = 20'hBBBBB; a.d1 = 1'b1; a.v1 = 1'b1;
        write(3, a);
        search(19'h12345, 1'b1, 10'h2A);
        search(19'h12345, 1'b1, 10'h2B);
        search(19'h12345, 1'b0, 10'h2A);

        b = '0;
        b.e = 1'b1; b.vppn = 19'h7FE00; b.ps = 6'd21; b.g = 1'b1; b.ppn1 = 20'h00C00; b.v1 = 1'b1;
        write(7, b);
        search(19'h7FF23, 1'b0, 10'h155);
        search(19'h7FE23, 1'b1, 10'h000);

        c = '0;
        c.e = 1'b1; c.vppn = 19'h0ABCD; c.ps = 6'd12; c.g = 1'b1; c.ppn0 = 20'h11111; c.v0 = 1'b1;
        c.plv0 = 2'd3; c.mat0 = 2'd1;
        write(9, c);
        write(2, c);
        search(19'h0ABCD, 1'b0, 10'h0);
        cz = c;
        cz.e = 1'b0;
        bus.we = 1'b1; bus.w_index = 4'd2; bus.w_entry = cz;
        cycle();
        bus.we = 1'b0;
        cycle();

        write(3, a);
        invalidate(3, 10'h0, 19'h0);
        search(19'h12345, 1'b1, 10'h2A);
        search(19'h7FF23, 1'b0, 10'h2A);
        search(19'h0ABCD, 1'b0, 10'h0);

        a2 = a;
        a2.vppn = 19'h54321;
        write(3, a);
        write(5, a2);
        invalidate(5, 10'h2A, 19'h12345);
        bus.r_index = 4'd5;
        search(19'h12345, 1'b1, 10'h2A);
        search(19'h54321, 1'b0, 10'h2A);
        bus.r_index = 4'd3;
        cycle();

        invalidate(9, 10'h2A, 19'h54321);
        search(19'h54321, 1'b1, 10'h2A);

        d = '0;
        d.e = 1'b1; d.vppn = 19'h00111; d.ps = 6'd12; d.g = 1'b1; d.ppn0 = 20'h44444; d.v0 = 1'b1;
        bus.we = 1'b1; bus.w_index = 4'd4; bus.w_entry = d;
        invalidate(0, 10'h0, 19'h0);
        bus.we = 1'b0;
        bus.r_index = 4'd4;
        search(19'h00111, 1'b0, 10'h0);
        search(19'h7FF23, 1'b0, 10'h0);
        bus.r_index = 4'd7;
        search(19'h0ABCD, 1'b0, 10'h0);

        for (int n = 0; n < 600; n++) begin
            bus.s_vppn     = pick_vppn();
            bus.s_va_bit12 = 1'($urandom);
            bus.s_asid     = pick_asid();
            bus.r_index    = 4'($urandom);
            bus.we         = ($urandom_range(0, 2) == 0);
            bus.w_index    = 4'($urandom);
            bus.w_entry    = rand_entry();
            bus.inv_valid  = ($urandom_range(0, 5) == 0);
            bus.inv_op     = 5'($urandom_range(0, 9));
            bus.inv_asid   = pick_asid();
            bus.inv_vppn   = pick_vppn();
            cycle();
        end
        bus.inv_valid = 1'b0;

        // Reset lands in the middle of a write: the write must be lost.
        a.e = 1'b1;
        bus.we = 1'b1; bus.w_index = 4'd3; bus.w_entry = a;
        bus.r_index = 4'd3;
        bus.s_vppn = 19'h12345; bus.s_va_bit12 = 1'b1; bus.s_asid = 10'h2A;
        resetn = 1'b0;
        model_reset();
        cycle();
        bus.we = 1'b0;
        resetn = 1'b1;
        repeat (3) cycle();

        done = 1'b1;
    end

endmodule

// File: doc/tlb_array.md
# tlb_array

Software-managed 16-entry fully associative TLB of the LoongArch core. It sits directly downstream of the address translator: it receives the translator's combinational search request (VPPN, VA bit 12, ASID) and returns hit/index/PPN/attributes in the same cycle. It also holds the entry storage written by TLBWR/TLBFILL, read by TLBRD, and invalidated by INVTLB. It supplies the TLBFILL victim index.

## Interface
- TLBNUM, 16: entry count, power of two.
- IDXW, 4: log2(TLBNUM).
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_vppn  in  19  search VA[31:13].
- s_va_bit12  in  1  search VA[12].
- s_asid  in  10  search ASID.
- s_found  out  1  any entry matched.
- s_index  out  IDXW  matched entry index.
- s_ppn  out  20  PPN of the selected half.
- s_ps  out  6  page size of the matched entry.
- s_plv, s_mat  out  2 each  PLV/MAT of the selected half.
- s_d, s_v  out  1 each  D/V of the selected half.
- we  in  1  write strobe, TLBWR/TLBFILL.
- w_index  in  IDXW  write target.
- w_entry  in  89  packed entry, format tlb_entry_t.
- r_index  in  IDXW  read index, TLBRD.
- r_entry  out  89  packed entry at r_index.
- inv_valid  in  1  INVTLB strobe.
- inv_op  in  5  INVTLB op.
- inv_asid  in  10  INVTLB ASID operand.
- inv_vppn  in  19  INVTLB VA[31:13] operand.
- inv_op_bad  out  1  inv_op > 6; combinational.
- fill_index  out  IDXW  TLBFILL victim.

## Operation
- Entry field order, MSB to LSB: e, vppn[18:0], ps[5:0], g, asid[9:0], ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0, ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1.
- Allowed ps values are 12 and 21; any other value is treated as 12.
- Entry match requires all of:
  - e = 1;
  - g = 1, or asid = s_asid;
  - VPPN compare: for ps = 12, vppn equals s_vppn on all 19 bits; for ps = 21, vppn[18:9] equals s_vppn[18:9].
- Half select: for ps = 12 the selector is s_va_bit12; for ps = 21 it is s_vppn[8] (VA bit 21). Selector 0 selects ppn0/plv0/mat0/d0/v0; selector 1 selects the ppn1 set.
- With multiple matches, the lowest index wins. This is deterministic, although software must never create multiple matches.
- On no match: s_found = 0, and s_index and all attribute outputs are 0.
- Search is purely combinational. Storage is written only on clock edges.
- INVTLB applies at the edge when inv_valid = 1. It clears e in every entry matching the op:
  - ops 0 and 1: all entries.
  - op 2: g = 1.
  - op 3: g = 0.
  - op 4: g = 0 and asid = inv_asid.
  - op 5: g = 0, asid = inv_asid, and VPPN match as in search.
  - op 6: (g = 1 or asid = inv_asid) and VPPN match.
  - ops 7 to 31: no state change; inv_op_bad = 1 while inv_valid = 1.
- Only the e bit is cleared; all other fields are retained.
- fill_index is a free-running IDXW-bit counter. It increments every cycle and wraps from TLBNUM-1 to 0.

## Timing
- Reset (resetn low, asynchronous): every e = 0, fill_index = 0, and all other fields = 0. Therefore s_found = 0 and r_entry = 0 immediately after reset.
- Reset asserted mid-write or mid-invalidate: reset wins and the operation is lost.
- Search and read latency is 0 cycles. A write or invalidate becomes visible to search and read in the cycle after the edge. A search in the same cycle as a write sees the old contents.
- we and inv_valid in the same cycle: invalidate is applied first, then the write. The written entry holds w_entry, even when the invalidate matches it.
- fill_index advances regardless of we/inv_valid. The consumer samples it in the cycle TLBFILL issues we.

## Structure
- Shared package tlb_pkg holds:
  - tlb_entry_t packed struct (89 bits) and the field widths;
  - INVTLB op constants;
  - PS_4K = 12 and PS_4M = 21.
- One sub-module, tlb_match: per-entry combinational compare (VPPN/ASID/G/ps) returning the hit and the half-select bit. It is instantiated TLBNUM times for search and TLBNUM times for invalidate.
- The top level holds the storage, the priority encoder, the half mux, the invalidate/write update, and the fill counter.

## Test plan
- Post-reset state: search vppn=0x00001, asid=0 -> s_found=0. r_index=5 -> r_entry=0. fill_index runs 0,1,2…15,0.
- 4K page:
  - Write index 3 with e=1, vppn=0x12345, ps=12, g=0, asid=0x2A, ppn0=0xAAAAA, v0=1, ppn1=0xBBBBB, d1=1, v1=1.
  - Search vppn 0x12345, bit12=1, asid 0x2A -> found, index 3, ppn 0xBBBBB, d=1.
  - Same search with asid 0x2B -> not found.
- 4M page:
  - Write index 7 with vppn=0x7FE00, ps=21, g=1, ppn1=0x00C00.
  - Search vppn 0x7FF23 (bit 8 set), any asid -> found, index 7, ppn 0x00C00, ps=21.
- Priority and write timing:
  - Identical matching entries at indices 9 and 2 -> s_index=2.
  - Write index 2 with e=0 and search it in the same cycle -> still index 2; the next cycle -> 9.
- INVTLB:
  - op 3 with entries g=0 and g=1 -> only the g=0 entries stop matching.
  - op 5 with asid 0x2A, vppn 0x12345 clears index 3 only.
  - op 9 -> inv_op_bad=1, no change.
  - op 0 with same-cycle we to index 4 -> only entry 4 is valid afterwards.
